// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock first-in/first-out buffer with a registered read
//            port and counter-decoded empty/full flags.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);

  // Pointer width; the counter gets one extra bit so it can hold DEPTH itself.
  localparam int              c_AW         = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL_COUNT = (c_AW + 1)'(DEPTH);
  localparam logic [c_AW-1:0] c_PTR_ONE    = c_AW'(1);
  localparam logic [c_AW:0]   c_CNT_ONE    = (c_AW + 1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_AW:0]         r_count;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic w_empty;
  logic w_full;
  logic w_wr_en;
  logic w_rd_en;

  // Flags come straight from the counter register, so they are glitch-free.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL_COUNT);

  // Accept decisions use the flag values from before the edge; a full FIFO
  // drops the write even when a read frees a slot in the same cycle.
  assign w_wr_en = wr && !w_full;
  assign w_rd_en = rd && !w_empty;

  assign empty    = w_empty;
  assign full     = w_full;
  assign data_out = r_data_out;

  // Storage array: written on accepted writes only, never reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Write pointer advances modulo DEPTH on each accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
    end
  end

  // Read pointer and registered output: the read returns the oldest entry,
  // never the one being written this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_data_out <= '0;
    end else if (w_rd_en) begin
      r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
      r_data_out <= r_mem[r_rd_ptr];
    end
  end

  // Occupancy counter: +1 on write only, -1 on read only, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Randomized self-checking bench for sync_fifo against a queue
//            based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr  = 1'b0;
  logic          rd  = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;

  int n_checks = 0;
  int n_fails  = 0;
  string phase = "init";

  // Reference model: a plain queue of bytes plus the last value read.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout = '0;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .rd       (rd),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then
  // compare all outputs on the falling edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
    bit wa;
    bit ra;
    wr = w; rd = r; data_in = d; rst = rs;
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_dout = '0;
    end else begin
      wa = w && (m_q.size() < DP);
      ra = r && (m_q.size() > 0);
      if (ra) m_dout = m_q.pop_front();
      if (wa) m_q.push_back(d);
    end
    @(negedge clk);
    chk("empty", {31'd0, empty}, {31'd0, m_q.size() == 0});
    chk("full",  {31'd0, full},  {31'd0, m_q.size() == DP});
    chk("dout",  {24'd0, data_out}, {24'd0, m_dout});
  endtask

  initial begin
    int wcnt;
    int rcnt;
    bit w;
    bit r;
    int occ;

    // Reset held two cycles with both requests active.
    phase = "reset";
    @(negedge clk);
    step(1'b1, 1'b1, 8'h77, 1'b1);
    step(1'b1, 1'b1, 8'h77, 1'b1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_dout",  {24'd0, data_out}, 32'd0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("rst_nothing_stored", {31'd0, empty}, 32'd1);

    // Fill with 0x01..0x10 then drain in order.
    phase = "fill";
    for (int i = 1; i <= DP; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
    chk("fill_full",  {31'd0, full},  32'd1);
    chk("fill_empty", {31'd0, empty}, 32'd0);
    phase = "drain";
    for (int i = 1; i <= DP; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_order", {24'd0, data_out}, i);
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Overflow: 0xAA written while full must never come back.
    phase = "overflow";
    for (int i = 0; i < DP; i++) step(1'b1, 1'b0, DW'(8'h30 + i), 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    for (int i = 0; i < DP; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("ovf_no_aa", {31'd0, data_out == 8'hAA}, 32'd0);
    end
    chk("ovf_empty", {31'd0, empty}, 32'd1);

    // Underflow: reading an empty FIFO holds the last value.
    phase = "underflow";
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf_hold",  {24'd0, data_out}, 32'h3F);
    chk("udf_empty", {31'd0, empty}, 32'd1);

    // Simultaneous read/write with 4 entries held.
    phase = "rw4";
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, DW'(8'h50 + i), 1'b0);
      chk("rw4_size", m_q.size(), 32'd4);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("rw4_last", {24'd0, data_out}, 32'h59);

    // Simultaneous on empty: only the write happens.
    phase = "rw_empty";
    step(1'b1, 1'b1, 8'h66, 1'b0);
    chk("rwe_hold",  {24'd0, data_out}, 32'h59);
    chk("rwe_empty", {31'd0, empty}, 32'd0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("rwe_read",  {24'd0, data_out}, 32'h66);

    // Simultaneous on full: only the read happens, write is lost.
    phase = "rw_full";
    for (int i = 0; i < DP; i++) step(1'b1, 1'b0, DW'(8'h80 + i), 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("rwf_dout", {24'd0, data_out}, 32'h80);
    chk("rwf_full", {31'd0, full}, 32'd0);
    for (int i = 0; i < DP - 1; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("rwf_no_ee", {31'd0, data_out == 8'hEE}, 32'd0);
    end
    chk("rwf_empty", {31'd0, empty}, 32'd1);

    // Wrap-around: 40 writes/40 reads, occupancy kept within 1..15.
    phase = "wrap";
    step(1'b1, 1'b0, 8'($urandom), 1'b0);
    wcnt = 1;
    rcnt = 0;
    for (int it = 0; it < 400 && (wcnt < 40 || rcnt < 39); it++) begin
      occ = m_q.size();
      w = (wcnt < 40) && (occ < DP - 1) && ($urandom_range(1, 0) == 1);
      r = (rcnt < 39) && ((occ >= 2) || w) && ($urandom_range(1, 0) == 1);
      if (w || r) step(w, r, 8'($urandom), 1'b0);
      if (w) wcnt++;
      if (r) rcnt++;
    end
    chk("wrap_counts", wcnt + rcnt, 32'd79);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("wrap_empty", {31'd0, empty}, 32'd1);

    // Unconstrained random traffic, including overflow/underflow attempts.
    phase = "random";
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom_range(40, 0) == 0));

    // Reset mid-operation discards contents.
    phase = "midrst";
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, DW'(8'h10 + i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_dout",  {24'd0, data_out}, 32'd0);
    step(1'b1, 1'b0, 8'h55, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("midrst_55",    {24'd0, data_out}, 32'h55);
    chk("midrst_empty2", {31'd0, empty}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
